// File: rtl/touch_pkg.sv
// Shared definitions for the touch filter and the downstream touch detector.
// Holds the press FSM encoding, coordinate width and the default timing constants.
package touch_pkg;

    localparam int COORD_W                 = 12;
    localparam int DEFAULT_TOL             = 64;
    localparam int DEFAULT_RELEASE_TIMEOUT = 2500000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        PRESSED = 2'd2
    } touch_state_t;

endpackage

// File: rtl/touch_filter_if.sv
// Raw sample stream from the panel controller and the conditioned coordinate stream.
// The panel/bench side uses master; the filter uses slave.
interface touch_filter_if;
    import touch_pkg::*;

    logic [COORD_W-1:0] raw_x;
    logic [COORD_W-1:0] raw_y;
    logic               raw_valid;
    logic [COORD_W-1:0] x_coord;
    logic [COORD_W-1:0] y_coord;
    logic               new_coord;
    logic               touching;

    modport master (
        output raw_x, raw_y, raw_valid,
        input  x_coord, y_coord, new_coord, touching
    );

    modport slave (
        input  raw_x, raw_y, raw_valid,
        output x_coord, y_coord, new_coord, touching
    );

endinterface

// File: rtl/touch_axis_accum.sv
// One axis of the touch filter: anchor register, inclusive tolerance window and
// rounding accumulator. avg already includes the sample currently presented.
module touch_axis_accum
    import touch_pkg::*;
#(
    parameter int SAMPLES_LOG2 = 2,
    parameter int TOL          = DEFAULT_TOL
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               add,
    input  logic               clear,
    input  logic [COORD_W-1:0] sample,
    output logic               in_window,
    output logic [COORD_W-1:0] avg
);

    localparam int                 ACC_W = COORD_W + SAMPLES_LOG2 + 1;
    localparam logic [ACC_W-1:0]   HALF  = ACC_W'(1) << (SAMPLES_LOG2 - 1);
    localparam logic [COORD_W:0]   TOL_V = (COORD_W + 1)'(TOL);

    logic [COORD_W-1:0]        anchor;
    logic [ACC_W-1:0]          acc;
    logic signed [COORD_W:0]   diff;
    logic [COORD_W:0]          diff_mag;

    // The extra sign bit keeps the full 0..4095 swing representable in both directions.
    always_comb begin
        diff      = $signed({1'b0, sample}) - $signed({1'b0, anchor});
        diff_mag  = diff[COORD_W] ? unsigned'(-diff) : unsigned'(diff);
        in_window = (diff_mag <= TOL_V);
        avg       = COORD_W'((acc + ACC_W'(sample) + HALF) >> SAMPLES_LOG2);
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            anchor <= '0;
            acc    <= '0;
        end else if (load) begin
            anchor <= sample;
            acc    <= ACC_W'(sample);
        end else if (add) begin
            acc <= acc + ACC_W'(sample);
        end
    end

endmodule

// File: rtl/touch_filter.sv
// Touch-panel sample conditioner: windowed acquisition, rounded averaging, one event per press.
// Define TOUCH_FILTER_REPEAT_EN to re-pulse new_coord every REPEAT_DELAY cycles while held.
module touch_filter
    import touch_pkg::*;
#(
    parameter int SAMPLES_LOG2    = 2,
    parameter int TOL             = DEFAULT_TOL,
    parameter int RELEASE_TIMEOUT = DEFAULT_RELEASE_TIMEOUT
`ifdef TOUCH_FILTER_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000
`endif
) (
    input logic           clock,
    input logic           reset,
    touch_filter_if.slave bus
);

    localparam int                SAMPLES    = 1 << SAMPLES_LOG2;
    localparam int                CNT_W      = SAMPLES_LOG2 + 1;
    localparam int                TMR_W      = $clog2(RELEASE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(SAMPLES - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX    = TMR_W'(RELEASE_TIMEOUT);

    touch_state_t       state, next_state;
    logic [CNT_W-1:0]   count;
    logic [TMR_W-1:0]   timer;
    logic [COORD_W-1:0] x_avg, y_avg, x_coord, y_coord;
    logic               x_win, y_win, expired;
    logic               load, add, clear_acc, accept;
    logic               new_coord, rpt_fire;

    assign expired = (timer == TMR_MAX);

    touch_axis_accum #(.SAMPLES_LOG2(SAMPLES_LOG2), .TOL(TOL)) u_x_accum (
        .clock(clock), .reset(reset), .load(load), .add(add), .clear(clear_acc),
        .sample(bus.raw_x), .in_window(x_win), .avg(x_avg)
    );

    touch_axis_accum #(.SAMPLES_LOG2(SAMPLES_LOG2), .TOL(TOL)) u_y_accum (
        .clock(clock), .reset(reset), .load(load), .add(add), .clear(clear_acc),
        .sample(bus.raw_y), .in_window(y_win), .avg(y_avg)
    );

    // A sample arriving on the expiry cycle wins, so timeouts are only taken without raw_valid.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        add        = 1'b0;
        clear_acc  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.raw_valid) begin
                    load       = 1'b1;
                    next_state = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (bus.raw_valid) begin
                    if (x_win && y_win) begin
                        if (count == LAST_COUNT) begin
                            accept     = 1'b1;
                            next_state = PRESSED;
                        end else begin
                            add = 1'b1;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end else if (expired) begin
                    clear_acc  = 1'b1;
                    next_state = IDLE;
                end
            end
            PRESSED: begin
                if (!bus.raw_valid && expired) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            count     <= '0;
            timer     <= '0;
            x_coord   <= '0;
            y_coord   <= '0;
            new_coord <= 1'b0;
        end else begin
            state     <= next_state;
            new_coord <= accept | rpt_fire;
            if (bus.raw_valid) begin
                timer <= '0;
            end else if (!expired) begin
                timer <= timer + 1'b1;
            end
            if (load) begin
                count <= CNT_W'(1);
            end else if (add) begin
                count <= count + 1'b1;
            end else if (clear_acc || accept) begin
                count <= '0;
            end
            if (accept) begin
                x_coord <= x_avg;
                y_coord <= y_avg;
            end
        end
    end

`ifdef TOUCH_FILTER_REPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_DELAY - 1);

    logic [RPT_W-1:0] rpt_count;

    // Held at zero outside PRESSED so every press starts a fresh repeat period.
    assign rpt_fire = (state == PRESSED) && (next_state == PRESSED) && (rpt_count == RPT_LAST);

    always_ff @(posedge clock) begin
        if (!reset || state != PRESSED || rpt_fire) begin
            rpt_count <= '0;
        end else begin
            rpt_count <= rpt_count + 1'b1;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    assign bus.x_coord   = x_coord;
    assign bus.y_coord   = y_coord;
    assign bus.new_coord = new_coord;
    assign bus.touching  = (state == PRESSED);

endmodule

// File: tb/tb_touch_filter.sv
// Self-checking bench for touch_filter: a queue-based press model checked every cycle,
// plus directed presses with hand-computed coordinates. Honours TOUCH_FILTER_REPEAT_EN.
module tb_touch_filter;
    import touch_pkg::*;

    localparam int LOG2    = 2;
    localparam int SAMPLES = 4;
    localparam int TOL_T   = 64;
    localparam int RT      = 300;
`ifdef TOUCH_FILTER_REPEAT_EN
    localparam int RD      = 100;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    touch_filter_if bus ();

    touch_filter #(
        .SAMPLES_LOG2(LOG2),
        .TOL(TOL_T),
        .RELEASE_TIMEOUT(RT)
`ifdef TOUCH_FILTER_REPEAT_EN
        ,
        .REPEAT_DELAY(RD)
`endif
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Model: a press is SAMPLES samples all within TOL of the first; release is silence > RT edges.
    int   cyc = 0;
    int   last_edge = 0;
    int   acq_x[$];
    int   acq_y[$];
    bit   pressed = 1'b0;
    int   exp_x = 0;
    int   exp_y = 0;
    bit   exp_new = 1'b0;
    bit   exp_touch = 1'b0;
`ifdef TOUCH_FILTER_REPEAT_EN
    int   accept_edge = 0;
`endif

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_step();
        int rx, ry, sx, sy;
        cyc++;
        exp_new = 1'b0;
        if (!reset) begin
            acq_x.delete();
            acq_y.delete();
            pressed = 1'b0;
            exp_x   = 0;
            exp_y   = 0;
        end else if (bus.raw_valid === 1'b1) begin
            last_edge = cyc;
            rx = int'(bus.raw_x);
            ry = int'(bus.raw_y);
            if (!pressed) begin
                if (acq_x.size() > 0 && iabs(rx - acq_x[0]) <= TOL_T && iabs(ry - acq_y[0]) <= TOL_T) begin
                    acq_x.push_back(rx);
                    acq_y.push_back(ry);
                end else begin
                    acq_x.delete();
                    acq_y.delete();
                    acq_x.push_back(rx);
                    acq_y.push_back(ry);
                end
                if (acq_x.size() == SAMPLES) begin
                    sx = 0;
                    sy = 0;
                    foreach (acq_x[i]) begin
                        sx += acq_x[i];
                        sy += acq_y[i];
                    end
                    exp_x   = (sx + SAMPLES / 2) / SAMPLES;
                    exp_y   = (sy + SAMPLES / 2) / SAMPLES;
                    exp_new = 1'b1;
                    pressed = 1'b1;
`ifdef TOUCH_FILTER_REPEAT_EN
                    accept_edge = cyc;
`endif
                    acq_x.delete();
                    acq_y.delete();
                end
            end
        end else if (cyc - last_edge > RT) begin
            pressed = 1'b0;
            acq_x.delete();
            acq_y.delete();
        end
`ifdef TOUCH_FILTER_REPEAT_EN
        if (pressed && !exp_new && ((cyc - accept_edge) % RD == 0)) begin
            exp_new = 1'b1;
        end
`endif
        exp_touch = pressed;
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
    end

    // Every-cycle comparison against the model; also records each observed pulse.
    int pulse_count = 0;
    int pulse_x = 0;
    int pulse_y = 0;

    initial forever begin
        @(negedge clock);
        vectors++;
        if (bus.x_coord !== 12'(exp_x) || bus.y_coord !== 12'(exp_y) ||
            bus.new_coord !== exp_new || bus.touching !== exp_touch) begin
            miscompares++;
            $display("[TB] FAIL model cycle %0d: got x=%0d y=%0d new=%b touching=%b, expected x=%0d y=%0d new=%b touching=%b",
                     cyc, bus.x_coord, bus.y_coord, bus.new_coord, bus.touching,
                     exp_x, exp_y, exp_new, exp_touch);
        end
        if (bus.new_coord === 1'b1) begin
            pulse_count++;
            pulse_x = int'(bus.x_coord);
            pulse_y = int'(bus.y_coord);
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Returns on the negedge just after the sample was taken.
    task automatic apply_stimulus(input int x, input int y);
        @(negedge clock);
        bus.raw_x     = 12'(x);
        bus.raw_y     = 12'(y);
        bus.raw_valid = 1'b1;
        @(negedge clock);
        bus.raw_valid = 1'b0;
    endtask

    task automatic measure_release(input string name);
        int n = 0;
        while (bus.touching === 1'b1 && n < RT + 50) begin
            @(negedge clock);
            n++;
        end
        check_output(name, n, RT + 1);
    endtask

    int p0;

    initial begin
        bus.raw_x     = '0;
        bus.raw_y     = '0;
        bus.raw_valid = 1'b0;
        reset         = 1'b0;
        idle_cycles(3);
        check_output("reset x_coord", int'(bus.x_coord), 0);
        check_output("reset y_coord", int'(bus.y_coord), 0);
        check_output("reset new_coord", int'(bus.new_coord), 0);
        check_output("reset touching", int'(bus.touching), 0);
        reset = 1'b1;
        idle_cycles(2);

        $display("[TB] basic press");
        p0 = pulse_count;
        apply_stimulus(1000, 2000);
        idle_cycles(99);
        apply_stimulus(1010, 1995);
        idle_cycles(99);
        apply_stimulus(1003, 2004);
        idle_cycles(99);
        apply_stimulus(998, 2001);
        idle_cycles(2);
        check_output("press1 pulses", pulse_count - p0, 1);
        check_output("press1 x", pulse_x, 1003);
        check_output("press1 y", pulse_y, 2000);
        check_output("press1 touching", int'(bus.touching), 1);

        $display("[TB] held press, boundary sample, release timing");
        for (int i = 0; i < 20; i++) begin
            idle_cycles(99);
            apply_stimulus(1500, 1500);
        end
        idle_cycles(RT - 1);
        apply_stimulus(1500, 1500);
        check_output("boundary sample keeps touching", int'(bus.touching), 1);
        measure_release("release delay");
        check_output("held x unchanged", int'(bus.x_coord), 1003);
`ifndef TOUCH_FILTER_REPEAT_EN
        check_output("held pulses", pulse_count - p0, 1);
`endif

        $display("[TB] restart on out-of-window sample");
        p0 = pulse_count;
        apply_stimulus(1000, 2000);
        idle_cycles(99);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1100, 2000);
            idle_cycles(99);
        end
        check_output("restart x", pulse_x, 1100);
        check_output("restart y", pulse_y, 2000);
`ifndef TOUCH_FILTER_REPEAT_EN
        check_output("restart pulses", pulse_count - p0, 1);
`endif
        idle_cycles(RT + 10);

        $display("[TB] tolerance edge 64 accepted");
        apply_stimulus(1000, 2000);
        for (int i = 0; i < 3; i++) begin
            idle_cycles(20);
            apply_stimulus(1064, 2000);
        end
        idle_cycles(2);
        check_output("tol64 x", pulse_x, 1048);
        idle_cycles(RT + 10);

        $display("[TB] tolerance edge 65 restarts");
        p0 = pulse_count;
        apply_stimulus(1000, 2000);
        for (int i = 0; i < 4; i++) begin
            idle_cycles(20);
            apply_stimulus(1065, 2000);
        end
        idle_cycles(2);
        check_output("tol65 x", pulse_x, 1065);
        check_output("tol65 touching", int'(bus.touching), 1);
        idle_cycles(RT + 10);

        $display("[TB] reset during acquisition");
        p0 = pulse_count;
        apply_stimulus(2000, 3000);
        idle_cycles(20);
        apply_stimulus(2010, 3000);
        idle_cycles(20);
        apply_stimulus(2020, 3000);
        reset = 1'b0;
        idle_cycles(1);
        check_output("mid reset x_coord", int'(bus.x_coord), 0);
        check_output("mid reset y_coord", int'(bus.y_coord), 0);
        check_output("mid reset touching", int'(bus.touching), 0);
        reset = 1'b1;
        apply_stimulus(2000, 3000);
        idle_cycles(RT + 20);
        check_output("post reset pulses", pulse_count - p0, 0);
        check_output("post reset x_coord", int'(bus.x_coord), 0);

`ifdef TOUCH_FILTER_REPEAT_EN
        $display("[TB] auto-repeat while held");
        p0 = pulse_count;
        apply_stimulus(500, 600);
        for (int i = 0; i < 3; i++) begin
            idle_cycles(20);
            apply_stimulus(500, 600);
        end
        idle_cycles(350);
        check_output("repeat pulses", pulse_count - p0, 4);
        check_output("repeat x", pulse_x, 500);
        check_output("repeat y", pulse_y, 600);
        check_output("repeat touching", int'(bus.touching), 0);
`endif

        idle_cycles(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
